// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: four-line external interrupt source with sync/edge capture, mask, fixed priority and reti handshake.
// Optional WAIT timeout is built when INT_TIMEOUT_EN is defined.
module ext_int_ctrl #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] src_req,
  input  logic       reti,
  input  logic       wr_en,
  input  logic [1:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic [3:0] ext_int,
  output logic       busy
);
  localparam int CW = $clog2((PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN) + 1);
  localparam logic [1:0] IDLE = 2'd0, PULSE = 2'd1, WAIT = 2'd2, GAP = 2'd3;
  logic [1:0] state;
  logic [3:0] s1, s2, s3, pending, mask, avail, sel, rise, w1c;
  logic [2:0] active_id, pick_id;
  logic [CW-1:0] cnt;
  logic reti_seen, timeout_flag, tmo, tf_clr, unused;
  assign busy = state != IDLE;
  assign rise = s2 & ~s3;
  assign avail = pending & mask;
  assign sel = avail & (~avail + 4'd1);
  assign w1c = (wr_en && addr == 2'd1) ? wr_data[3:0] : 4'd0;
  assign tf_clr = wr_en && addr == 2'd2;
  assign unused = ^wr_data[7:4];
  always_comb pick_id = avail[0] ? 3'd1 : avail[1] ? 3'd2 : avail[2] ? 3'd3 : avail[3] ? 3'd4 : 3'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, s3, pending} <= '0;
      mask <= 4'hF;
      rd_data <= '0;
      ext_int <= '0;
      state <= IDLE;
      active_id <= '0;
      cnt <= '0;
      reti_seen <= 1'b0;
    end else begin
      {s1, s2, s3} <= {src_req, s1, s2};
      // a fresh edge beats both the W1C and the dispatch clear
      pending <= (pending & ~w1c & ~((state == IDLE) ? sel : 4'd0)) | rise;
      if (wr_en && addr == 2'd0) mask <= wr_data[3:0];
      rd_data <= addr == 2'd0 ? {4'd0, mask} :
                 addr == 2'd1 ? {4'd0, pending} :
                 addr == 2'd2 ? {3'd0, timeout_flag, busy, active_id} : 8'd0;
      case (state)
        IDLE: if (|avail) begin
          state <= PULSE;
          ext_int <= sel;
          active_id <= pick_id;
          cnt <= CW'(1);
          reti_seen <= 1'b0;
        end
        PULSE: if (cnt == CW'(PULSE_LEN)) begin
          ext_int <= '0;
          state <= (reti_seen || reti) ? GAP : WAIT;
          cnt <= CW'(1);
        end else begin
          cnt <= cnt + CW'(1);
          reti_seen <= reti_seen | reti;
        end
        WAIT: if (reti || tmo) begin
          state <= GAP;
          cnt <= CW'(1);
        end
        GAP: if (cnt == CW'(GAP_LEN)) begin
          state <= IDLE;
          active_id <= '0;
        end else cnt <= cnt + CW'(1);
      endcase
    end
  end
`ifdef INT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == WAIT && !reti && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      timeout_flag <= 1'b0;
    end else begin
      tcnt <= state == WAIT ? tcnt + TW'(1) : '0;
      timeout_flag <= tmo | (timeout_flag & ~tf_clr);
    end
  end
`else
  logic unused_t;
  assign unused_t = tf_clr ^ (TIMEOUT != 0);
  assign tmo = 1'b0;
  assign timeout_flag = 1'b0;
`endif
endmodule
